// File: rtl/if_stage.sv
// Instruction fetch stage of the 16-bit pipeline.
// Owns the program counter and presents it as the fetch address to a
// combinational instruction memory. The returned word and its PC are
// captured into the IF/ID register on the same edge that advances the PC.
// Handles hazard freeze, execute-stage redirect/flush and a halt opcode.
//
// Port handshake: there is no valid/ready pair on this block. The stage
// always drives pc_out, and instr_in must hold the memory word for pc_out in
// the same cycle. if_id_valid qualifies the IF/ID contents (0 = bubble).
// freeze acts as the downstream "not ready": while it is high (and no
// redirect is pending) nothing moves and nothing is lost.
module if_stage #(
    parameter int                    WORD_LEN    = 16,
    parameter logic [WORD_LEN-1:0]   PC_RESET    = 16'd8,
    parameter int                    PC_STEP     = 4,
    parameter logic [3:0]            HALT_OPCODE = 4'b1111
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                branch_taken,
    input  logic [WORD_LEN-1:0] branch_target,
    input  logic [WORD_LEN-1:0] instr_in,
    output logic [WORD_LEN-1:0] pc_out,
    output logic [WORD_LEN-1:0] if_id_pc,
    output logic [WORD_LEN-1:0] if_id_instr,
    output logic                if_id_valid,
    output logic                halted,
    output logic [15:0]         fetch_count,
    output logic                state_dbg
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t              r_state;
    logic [WORD_LEN-1:0] r_pc;
    logic [WORD_LEN-1:0] r_if_id_pc;
    logic [WORD_LEN-1:0] r_if_id_instr;
    logic                r_if_id_valid;
    logic [15:0]         r_fetch_count;

    state_t              w_state_nxt;
    logic [WORD_LEN-1:0] w_pc_nxt;
    logic [WORD_LEN-1:0] w_if_id_pc_nxt;
    logic [WORD_LEN-1:0] w_if_id_instr_nxt;
    logic                w_if_id_valid_nxt;
    logic [15:0]         w_fetch_count_nxt;
    logic                w_is_halt;

    // The opcode lives in the top nibble of the fetched word.
    assign w_is_halt = (instr_in[WORD_LEN-1 -: 4] == HALT_OPCODE);

    // Next-state and next-register values; priority is
    // branch > freeze > halt detect > normal fetch while running.
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_if_id_pc_nxt    = r_if_id_pc;
        w_if_id_instr_nxt = r_if_id_instr;
        w_if_id_valid_nxt = r_if_id_valid;
        w_fetch_count_nxt = r_fetch_count;
        case (r_state)
            S_RUN: begin
                if (branch_taken) begin
                    // Redirect wins over freeze; the wrong-path word is dropped.
                    w_pc_nxt          = branch_target;
                    w_if_id_pc_nxt    = '0;
                    w_if_id_instr_nxt = '0;
                    w_if_id_valid_nxt = 1'b0;
                end else if (freeze) begin
                    // Everything holds; defaults already do that.
                    w_pc_nxt = r_pc;
                end else if (w_is_halt) begin
                    // The halt word itself is never forwarded to decode.
                    w_if_id_pc_nxt    = '0;
                    w_if_id_instr_nxt = '0;
                    w_if_id_valid_nxt = 1'b0;
                    w_state_nxt       = S_HALT;
                end else begin
                    w_pc_nxt          = r_pc + WORD_LEN'(PC_STEP);
                    w_if_id_pc_nxt    = r_pc;
                    w_if_id_instr_nxt = instr_in;
                    w_if_id_valid_nxt = 1'b1;
                    if (r_fetch_count != 16'hFFFF) begin
                        w_fetch_count_nxt = r_fetch_count + 16'd1;
                    end
                end
            end
            S_HALT: begin
                // Bubble every cycle; only a redirect can restart fetch,
                // which lets an older branch cancel a speculative halt.
                w_if_id_pc_nxt    = '0;
                w_if_id_instr_nxt = '0;
                w_if_id_valid_nxt = 1'b0;
                if (branch_taken) begin
                    w_pc_nxt    = branch_target;
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    // State and datapath registers; synchronous reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_RUN;
            r_pc          <= PC_RESET;
            r_if_id_pc    <= '0;
            r_if_id_instr <= '0;
            r_if_id_valid <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_if_id_pc    <= w_if_id_pc_nxt;
            r_if_id_instr <= w_if_id_instr_nxt;
            r_if_id_valid <= w_if_id_valid_nxt;
            r_fetch_count <= w_fetch_count_nxt;
        end
    end

    assign pc_out      = r_pc;
    assign if_id_pc    = r_if_id_pc;
    assign if_id_instr = r_if_id_instr;
    assign if_id_valid = r_if_id_valid;
    assign fetch_count = r_fetch_count;
    assign halted      = (r_state == S_HALT);
    assign state_dbg   = r_state;

endmodule

// File: tb/tb_if_stage.sv
// Directed and randomised bench for if_stage. A small instruction memory
// table feeds instr_in from pc_out; expected IF/ID captures are queued as
// stimulus is applied and retired whenever fetch_count advances.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] instr_in;
  logic [15:0] pc_out;
  logic [15:0] if_id_pc;
  logic [15:0] if_id_instr;
  logic        if_id_valid;
  logic        halted;
  logic [15:0] fetch_count;
  logic        state_dbg;

  int vec_cnt;
  int err_cnt;
  logic [31:0] exp_q[$];

  if_stage dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .instr_in     (instr_in),
    .pc_out       (pc_out),
    .if_id_pc     (if_id_pc),
    .if_id_instr  (if_id_instr),
    .if_id_valid  (if_id_valid),
    .halted       (halted),
    .fetch_count  (fetch_count),
    .state_dbg    (state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // program memory contents
  function automatic logic [15:0] word_at(input logic [15:0] a);
    case (a)
      16'd8:    return 16'h3709;
      16'd12:   return 16'h300F;
      16'd16:   return 16'h3F07;
      16'd20:   return 16'h1234;
      16'd24:   return 16'h2222;
      16'd28:   return 16'hF000;
      16'h0030: return 16'h7170;
      16'hFFFC: return 16'h5555;
      16'h0000: return 16'h6666;
      default:  return 16'h0A0A;
    endcase
  endfunction

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // one clock: drive inputs, memory answers for current pc_out, sample #1 after edge
  task automatic step(input logic r, input logic b, input logic [15:0] t, input logic f);
    logic [15:0] prev_cnt;
    logic [31:0] exp_w;
    prev_cnt      = fetch_count;
    rst           = r;
    branch_taken  = b;
    branch_target = t;
    freeze        = f;
    instr_in      = word_at(pc_out);
    @(posedge clk);
    #1;
    rst          = 1'b0;
    branch_taken = 1'b0;
    freeze       = 1'b0;
    if (!r && fetch_count !== prev_cnt) begin
      vec_cnt++;
      if (exp_q.size() == 0) begin
        err_cnt++;
        $display("FAIL sb_unexpected: got pc=%h instr=%h with nothing expected", if_id_pc, if_id_instr);
      end else begin
        exp_w = exp_q.pop_front();
        if ({if_id_pc, if_id_instr} !== exp_w || if_id_valid !== 1'b1) begin
          err_cnt++;
          $display("FAIL sb_capture: got pc=%h instr=%h v=%b expected pc=%h instr=%h v=1",
                   if_id_pc, if_id_instr, if_id_valid, exp_w[31:16], exp_w[15:0]);
        end
      end
    end
  endtask

  task automatic test_reset;
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    check16("reset_pc", pc_out, 16'd8);
    check16("reset_ifid_pc", if_id_pc, 16'h0);
    check16("reset_ifid_instr", if_id_instr, 16'h0);
    check16("reset_valid", {15'b0, if_id_valid}, 16'h0);
    check16("reset_halted", {15'b0, halted}, 16'h0);
    check16("reset_count", fetch_count, 16'h0);
  endtask

  task automatic test_run;
    exp_q.push_back({16'd8, 16'h3709});
    step(1'b0, 1'b0, 16'h0, 1'b0);
    check16("run_pc", pc_out, 16'd12);
    check16("run_ifid_pc", if_id_pc, 16'd8);
    check16("run_ifid_instr", if_id_instr, 16'h3709);
  endtask

  task automatic test_freeze;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'b1);
      check16("frz_pc", pc_out, 16'd12);
      check16("frz_ifid", {if_id_pc[7:0], if_id_instr[15:8]}, {8'd8, 8'h37});
      check16("frz_valid", {15'b0, if_id_valid}, 16'd1);
      check16("frz_count", fetch_count, 16'd1);
    end
    exp_q.push_back({16'd12, 16'h300F});
    step(1'b0, 1'b0, 16'h0, 1'b0);
    check16("frz_resume_pc", pc_out, 16'd16);
    exp_q.push_back({16'd16, 16'h3F07});
    step(1'b0, 1'b0, 16'h0, 1'b0);
    check16("run3_pc", pc_out, 16'd20);
    check16("run3_count", fetch_count, 16'd3);
  endtask

  task automatic test_branch_freeze;
    step(1'b0, 1'b1, 16'h0030, 1'b1);
    check16("br_pc", pc_out, 16'h0030);
    check16("br_valid", {15'b0, if_id_valid}, 16'h0);
    check16("br_flush_pc", if_id_pc, 16'h0);
    check16("br_flush_instr", if_id_instr, 16'h0);
    check16("br_count", fetch_count, 16'd3);
    exp_q.push_back({16'h0030, 16'h7170});
    step(1'b0, 1'b0, 16'h0, 1'b0);
    check16("br_after_valid", {15'b0, if_id_valid}, 16'd1);
    check16("br_after_pc", pc_out, 16'h0034);
  endtask

  task automatic test_halt;
    step(1'b0, 1'b1, 16'd20, 1'b0);
    exp_q.push_back({16'd20, 16'h1234});
    step(1'b0, 1'b0, 16'h0, 1'b0);
    exp_q.push_back({16'd24, 16'h2222});
    step(1'b0, 1'b0, 16'h0, 1'b0);
    check16("pre_halt_pc", pc_out, 16'd28);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    check16("halt_pc", pc_out, 16'd28);
    check16("halt_flag", {15'b0, halted}, 16'd1);
    check16("halt_state_dbg", {15'b0, state_dbg}, 16'd1);
    check16("halt_valid", {15'b0, if_id_valid}, 16'h0);
    check16("halt_count", fetch_count, 16'd6);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'($urandom_range(0, 1)));
      check16("halt_hold_pc", pc_out, 16'd28);
      check16("halt_hold_flag", {15'b0, halted}, 16'd1);
      check16("halt_hold_valid", {15'b0, if_id_valid}, 16'h0);
      check16("halt_hold_count", fetch_count, 16'd6);
    end
    step(1'b0, 1'b1, 16'd8, 1'b0);
    check16("unhalt_flag", {15'b0, halted}, 16'h0);
    check16("unhalt_pc", pc_out, 16'd8);
    check16("unhalt_valid", {15'b0, if_id_valid}, 16'h0);
    exp_q.push_back({16'd8, 16'h3709});
    step(1'b0, 1'b0, 16'h0, 1'b0);
    check16("resume_pc", pc_out, 16'd12);
    check16("resume_count", fetch_count, 16'd7);
  endtask

  task automatic test_wrap;
    step(1'b0, 1'b1, 16'hFFFC, 1'b0);
    exp_q.push_back({16'hFFFC, 16'h5555});
    step(1'b0, 1'b0, 16'h0, 1'b0);
    check16("wrap_pc", pc_out, 16'h0000);
    exp_q.push_back({16'h0000, 16'h6666});
    step(1'b0, 1'b0, 16'h0, 1'b0);
    check16("wrap_next_pc", pc_out, 16'h0004);
    check16("wrap_count", fetch_count, 16'd9);
  endtask

  // random freeze pattern over a straight-line region: no loss, no duplicates
  task automatic test_back_to_back;
    logic [15:0] a;
    logic        f;
    int          n;
    step(1'b0, 1'b1, 16'h0100, 1'b0);
    a = 16'h0100;
    n = 0;
    for (int i = 0; i < 24; i++) begin
      f = 1'($urandom_range(0, 1));
      if (!f) begin
        exp_q.push_back({a, 16'h0A0A});
        a = a + 16'd4;
        n++;
      end
      step(1'b0, 1'b0, 16'h0, f);
    end
    check16("b2b_pc", pc_out, a);
    check16("b2b_count", fetch_count, 16'(9 + n));
  endtask

  task automatic test_reset_mid;
    step(1'b0, 1'b0, 16'h0, 1'b1);
    step(1'b1, 1'b1, 16'h0030, 1'b1);
    check16("rmid_pc", pc_out, 16'd8);
    check16("rmid_ifid_pc", if_id_pc, 16'h0);
    check16("rmid_ifid_instr", if_id_instr, 16'h0);
    check16("rmid_valid", {15'b0, if_id_valid}, 16'h0);
    check16("rmid_halted", {15'b0, halted}, 16'h0);
    check16("rmid_count", fetch_count, 16'h0);
  endtask

  initial begin
    vec_cnt       = 0;
    err_cnt       = 0;
    rst           = 1'b1;
    freeze        = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 16'h0;
    instr_in      = 16'h0;
    @(negedge clk);
    test_reset();
    test_run();
    test_freeze();
    test_branch_freeze();
    test_halt();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    vec_cnt++;
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL sb_leftover: got %0d pending captures expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
